// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - parametrised iterative shift-add multiplier with RV-style op select
module seq_mul_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 kill,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * WIDTH + BITS_PER_CYCLE;
    localparam int PW = WIDTH + BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic                   neg_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [AW-1:0]          acc_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       result_q;
    logic [2*WIDTH-1:0]     product_q;

    logic                   sign1;
    logic                   sign2;
    logic [WIDTH-1:0]       mag1;
    logic [WIDTH-1:0]       mag2;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [PW-1:0]          partial;
    logic [AW-1:0]          acc_d;
    logic [2*WIDTH-1:0]     prod_mag;
    logic [2*WIDTH-1:0]     prod_d;

    always_comb begin
        sign1    = ((op == 2'b01) || (op == 2'b10)) && in1[WIDTH-1];
        sign2    = (op == 2'b01) && in2[WIDTH-1];
        mag1     = sign1 ? (~in1 + 1'b1) : in1;
        mag2     = sign2 ? (~in2 + 1'b1) : in2;
        digit    = mplier_q[BITS_PER_CYCLE-1:0];
        partial  = {{BITS_PER_CYCLE{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, digit};
        // Partial products enter at bit WIDTH; N right shifts bring digit j to weight 2^(j*BPC).
        acc_d    = (acc_q + {partial, {WIDTH{1'b0}}}) >> BITS_PER_CYCLE;
        prod_mag = acc_q[2*WIDTH-1:0];
        prod_d   = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q     <= op;
                        neg_q    <= sign1 ^ sign2;
                        mcand_q  <= mag1;
                        mplier_q <= mag2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CW'(N - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!kill) begin
                        product_q <= prod_d;
                        result_q  <= (op_q == 2'b00) ? prod_d[WIDTH-1:0]
                                                     : prod_d[2*WIDTH-1:WIDTH];
                        done_q    <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign product = product_q;

endmodule
